block_lock_ctrl: RTL and testbench

Receive-side block-lock controller for the 10GBASE-R PCS. It sits directly after the 64b/66b gearbox: it consumes the gearbox sync-header stream (`head`/`head_valid`) and drives the gearbox `slip` input until 64 consecutive valid sync headers are seen. After lock it monitors header errors and drops lock on 16 invalid headers within a 64-header window. It also reports lock status and, optionally, slip and lock-loss statistics.

---
 rtl/pcs_rx_pkg.sv | 20 ++
 rtl/block_lock_ctrl_if.sv | 21 ++
 rtl/sat_cnt.sv | 35 +++
 rtl/block_lock_ctrl.sv | 157 +++++++++++++++
 tb/tb_block_lock_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcs_rx_pkg.sv
// Shared definitions for the 10GBASE-R receive PCS: block-lock FSM states,
// sync-header codes and the width of the status counters.
package pcs_rx_pkg;

  typedef enum logic {
    TEST_SH   = 1'b0,
    SLIP_WAIT = 1'b1
  } bl_state_t;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam int STAT_CNT_W = 16;

  // Only 01 and 10 are legal 64b/66b sync headers.
  function automatic logic sh_is_valid(input logic [1:0] head);
    return (head == SH_DATA) || (head == SH_CTRL);
  endfunction

endpackage

// File: rtl/block_lock_ctrl_if.sv
// Gearbox <-> block-lock handshake: sync header stream in, slip request out.
// master = gearbox side, slave = block-lock controller side.
interface block_lock_ctrl_if;

  logic [1:0] head;
  logic       head_valid;
  logic       slip;

  modport master (
    output head,
    output head_valid,
    input  slip
  );

  modport slave (
    input  head,
    input  head_valid,
    output slip
  );

endinterface

// File: rtl/sat_cnt.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones.
module sat_cnt
  import pcs_rx_pkg::*;
#(
  parameter int W = STAT_CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: add one unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/block_lock_ctrl.sv
// 10GBASE-R receive block-lock controller. Watches the gearbox sync headers,
// slips the gearbox until 64 consecutive valid headers are seen, then drops
// lock on 16 invalid headers within a 64-header window.
// Optional build macro BLOCK_LOCK_STATUS_CNT_EN adds saturating slip and
// lock-loss counters; without it both counter outputs are tied to zero.
module block_lock_ctrl
  import pcs_rx_pkg::bl_state_t;
  import pcs_rx_pkg::STAT_CNT_W;
  import pcs_rx_pkg::sh_is_valid;
#(
  parameter int SH_CNT_MAX  = 64,
  parameter int INVALID_MAX = 16,
  parameter int SLIP_WAIT   = 80   // must cover the gearbox slip latency (70)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  block_lock_ctrl_if.slave      gb,
  output logic                  block_lock_o,
  output logic [STAT_CNT_W-1:0] slip_cnt_o,
  output logic [STAT_CNT_W-1:0] lock_loss_cnt_o
);

  localparam int SH_W   = 7;
  localparam int INV_W  = $clog2(INVALID_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT);

  localparam logic [SH_W-1:0]   SH_MAX    = SH_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]  INV_MAX   = INV_W'(INVALID_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SLIP_WAIT - 1);

  bl_state_t          state_q, state_d;
  logic [SH_W-1:0]    sh_cnt_q, sh_cnt_d;
  logic [INV_W-1:0]   inv_cnt_q, inv_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               lock_q, lock_d;
  logic               slip_q, slip_d;

  logic               hdr_ok;
  logic [SH_W-1:0]    sh_inc;
  logic [INV_W-1:0]   inv_inc;

  assign hdr_ok  = sh_is_valid(gb.head);
  assign sh_inc  = sh_cnt_q + SH_W'(1);
  assign inv_inc = inv_cnt_q + INV_W'(1);

  // Next-state logic: header counting in TEST_SH, blind countdown in SLIP_WAIT.
  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    inv_cnt_d  = inv_cnt_q;
    wait_cnt_d = wait_cnt_q;
    lock_d     = lock_q;
    slip_d     = 1'b0;

    case (state_q)
      pcs_rx_pkg::TEST_SH: begin
        if (gb.head_valid) begin
          if (!lock_q) begin
            if (!hdr_ok) begin
              // Misaligned: restart the search one bit further along.
              sh_cnt_d   = '0;
              inv_cnt_d  = '0;
              slip_d     = 1'b1;
              wait_cnt_d = WAIT_LOAD;
              state_d    = pcs_rx_pkg::SLIP_WAIT;
            end else if (sh_inc == SH_MAX) begin
              lock_d   = 1'b1;
              sh_cnt_d = '0;
            end else begin
              sh_cnt_d = sh_inc;
            end
          end else begin
            // Loss of lock has priority over closing the window.
            if (!hdr_ok && (inv_inc == INV_MAX)) begin
              lock_d     = 1'b0;
              sh_cnt_d   = '0;
              inv_cnt_d  = '0;
              slip_d     = 1'b1;
              wait_cnt_d = WAIT_LOAD;
              state_d    = pcs_rx_pkg::SLIP_WAIT;
            end else if (sh_inc == SH_MAX) begin
              sh_cnt_d  = '0;
              inv_cnt_d = '0;
            end else begin
              sh_cnt_d  = sh_inc;
              inv_cnt_d = hdr_ok ? inv_cnt_q : inv_inc;
            end
          end
        end
      end

      pcs_rx_pkg::SLIP_WAIT: begin
        // Headers are meaningless until the gearbox has realigned.
        if (wait_cnt_q == '0) begin
          state_d   = pcs_rx_pkg::TEST_SH;
          sh_cnt_d  = '0;
          inv_cnt_d = '0;
          lock_d    = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end

      default: begin
        state_d = pcs_rx_pkg::TEST_SH;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= pcs_rx_pkg::TEST_SH;
      sh_cnt_q   <= '0;
      inv_cnt_q  <= '0;
      wait_cnt_q <= '0;
      lock_q     <= 1'b0;
      slip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      inv_cnt_q  <= inv_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      lock_q     <= lock_d;
      slip_q     <= slip_d;
    end
  end

  assign gb.slip      = slip_q;
  assign block_lock_o = lock_q;

`ifdef BLOCK_LOCK_STATUS_CNT_EN
  // Index 0 counts slip pulses, index 1 counts falling edges of lock.
  logic [1:0]            stat_inc;
  logic [STAT_CNT_W-1:0] stat_cnt [2];

  assign stat_inc[0] = slip_d;
  assign stat_inc[1] = lock_q & ~lock_d;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_stat
    sat_cnt #(.W(STAT_CNT_W)) u_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .inc_i   (stat_inc[gi]),
      .cnt_o   (stat_cnt[gi])
    );
  end

  assign slip_cnt_o      = stat_cnt[0];
  assign lock_loss_cnt_o = stat_cnt[1];
`else
  assign slip_cnt_o      = '0;
  assign lock_loss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_block_lock_ctrl.sv
// Directed bench for block_lock_ctrl, including a closed-loop gearbox model.
module tb_block_lock_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        block_lock;
  logic [15:0] slip_cnt;
  logic [15:0] loss_cnt;

  block_lock_ctrl_if gb_if ();

  block_lock_ctrl dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .gb              (gb_if),
    .block_lock_o    (block_lock),
    .slip_cnt_o      (slip_cnt),
    .lock_loss_cnt_o (loss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int slip_hi_cycles = 0;

  // Number of clock cycles during which slip was high.
  always @(posedge clk) begin
    if (gb_if.slip === 1'b1) slip_hi_cycles++;
  end

  // Counter outputs are only live in the statistics build.
  function automatic logic [15:0] stat_exp(input int n);
`ifdef BLOCK_LOCK_STATUS_CNT_EN
    return 16'(n);
`else
    return 16'(n * 0);
`endif
  endfunction

  // Gearbox model data: hashed payload bits, sync header at bits 0/1.
  function automatic logic mix_bit(input int unsigned n, input int unsigned p);
    logic [31:0] h;
    h = (n * 32'h9E3779B1) ^ (p * 32'h85EBCA77 + 32'h01234567);
    h = h ^ (h >> 15);
    h = h * 32'h2C1B3C6D;
    h = h ^ (h >> 12);
    h = h * 32'h297A2D39;
    h = h ^ (h >> 15);
    return h[7];
  endfunction

  function automatic logic blk_bit(input int unsigned n, input int unsigned p);
    if (p == 0) return mix_bit(n, 0);
    if (p == 1) return ~mix_bit(n, 0);
    return mix_bit(n, p);
  endfunction

  function automatic logic [1:0] gb_head(input int unsigned n, input int unsigned off);
    logic b0, b1;
    b0 = blk_bit(n, off);
    b1 = (off == 65) ? blk_bit(n + 1, 0) : blk_bit(n, off + 1);
    return {b1, b0};
  endfunction

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    gb_if.head_valid = 1'b0;
    gb_if.head = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One header, followed by a one-cycle valid gap; returns at the negedge
  // after the sampling edge.
  task automatic hdr(input logic [1:0] h);
    @(negedge clk);
    gb_if.head = h;
    gb_if.head_valid = 1'b1;
    @(negedge clk);
    gb_if.head_valid = 1'b0;
  endtask

  task automatic test_reset;
    gb_if.head = 2'b00;
    gb_if.head_valid = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (block_lock !== 1'b0) begin errors++; $display("FAIL rst_lock got %b exp 0", block_lock); end
    checks++; if (gb_if.slip !== 1'b0) begin errors++; $display("FAIL rst_slip got %b exp 0", gb_if.slip); end
    checks++; if (slip_cnt !== 16'h0) begin errors++; $display("FAIL rst_slip_cnt got %h exp 0000", slip_cnt); end
    checks++; if (loss_cnt !== 16'h0) begin errors++; $display("FAIL rst_loss_cnt got %h exp 0000", loss_cnt); end
    gb_if.head_valid = 1'b0;
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_acquire;
    int base;
    do_reset;
    base = slip_hi_cycles;
    for (int i = 1; i <= 64; i++) begin
      hdr((i % 2 == 1) ? 2'b01 : 2'b10);
      if (i == 63) begin
        checks++; if (block_lock !== 1'b0) begin errors++; $display("FAIL acq_early got %b exp 0", block_lock); end
      end
    end
    checks++; if (block_lock !== 1'b1) begin errors++; $display("FAIL acq_lock got %b exp 1", block_lock); end
    checks++; if (slip_hi_cycles - base !== 0) begin errors++; $display("FAIL acq_noslip got %0d exp 0", slip_hi_cycles - base); end
    $display("test_acquire done");
  endtask

  task automatic test_slip_unlocked;
    int base;
    do_reset;
    for (int i = 1; i <= 9; i++) hdr(2'b01);
    hdr(2'b00);
    base = slip_hi_cycles;
    checks++; if (gb_if.slip !== 1'b1) begin errors++; $display("FAIL slip_pulse got %b exp 1", gb_if.slip); end
    checks++; if (slip_cnt !== stat_exp(1)) begin errors++; $display("FAIL slip_cnt1 got %h exp %h", slip_cnt, stat_exp(1)); end
    // 80 cycles of invalid headers must all be ignored.
    gb_if.head = 2'b11;
    gb_if.head_valid = 1'b1;
    repeat (80) @(negedge clk);
    gb_if.head_valid = 1'b0;
    checks++; if (slip_hi_cycles - base !== 1) begin errors++; $display("FAIL slip_width got %0d exp 1", slip_hi_cycles - base); end
    for (int i = 1; i <= 64; i++) begin
      hdr(2'b10);
      if (i == 63) begin
        checks++; if (block_lock !== 1'b0) begin errors++; $display("FAIL relock_early got %b exp 0", block_lock); end
      end
    end
    checks++; if (block_lock !== 1'b1) begin errors++; $display("FAIL relock got %b exp 1", block_lock); end
    checks++; if (slip_cnt !== stat_exp(1)) begin errors++; $display("FAIL slip_cnt_hold got %h exp %h", slip_cnt, stat_exp(1)); end
    $display("test_slip_unlocked done");
  endtask

  // Runs from the locked state left by test_slip_unlocked.
  task automatic test_error_tolerance;
    int base;
    int inv;
    base = slip_hi_cycles;
    inv = 0;
    for (int i = 1; i <= 64; i++) begin
      if ((i % 4 == 0) && (inv < 15)) begin
        hdr((inv % 2 == 0) ? 2'b00 : 2'b11);
        inv++;
      end else begin
        hdr(2'b01);
      end
    end
    checks++; if (block_lock !== 1'b1) begin errors++; $display("FAIL tol_win1 got %b exp 1", block_lock); end
    checks++; if (slip_hi_cycles - base !== 0) begin errors++; $display("FAIL tol_noslip got %0d exp 0", slip_hi_cycles - base); end
    for (int i = 1; i <= 15; i++) hdr(2'b11);
    checks++; if (block_lock !== 1'b1) begin errors++; $display("FAIL tol_win2_15 got %b exp 1", block_lock); end
    hdr(2'b00);
    checks++; if (block_lock !== 1'b0) begin errors++; $display("FAIL tol_loss got %b exp 0", block_lock); end
    checks++; if (gb_if.slip !== 1'b1) begin errors++; $display("FAIL tol_slip got %b exp 1", gb_if.slip); end
    checks++; if (loss_cnt !== stat_exp(1)) begin errors++; $display("FAIL tol_loss_cnt got %h exp %h", loss_cnt, stat_exp(1)); end
    checks++; if (slip_cnt !== stat_exp(2)) begin errors++; $display("FAIL tol_slip_cnt got %h exp %h", slip_cnt, stat_exp(2)); end
    @(negedge clk);
    checks++; if (gb_if.slip !== 1'b0) begin errors++; $display("FAIL tol_slip_fall got %b exp 0", gb_if.slip); end
    $display("test_error_tolerance done");
  endtask

  task automatic test_simultaneous;
    do_reset;
    for (int i = 1; i <= 64; i++) hdr(2'b01);
    checks++; if (block_lock !== 1'b1) begin errors++; $display("FAIL sim_lock got %b exp 1", block_lock); end
    for (int i = 1; i <= 64; i++) begin
      hdr((i <= 48) ? 2'b10 : 2'b00);
      if (i == 63) begin
        checks++; if (block_lock !== 1'b1) begin errors++; $display("FAIL sim_63 got %b exp 1", block_lock); end
      end
    end
    checks++; if (block_lock !== 1'b0) begin errors++; $display("FAIL sim_loss got %b exp 0", block_lock); end
    checks++; if (gb_if.slip !== 1'b1) begin errors++; $display("FAIL sim_slip got %b exp 1", gb_if.slip); end
    checks++; if (loss_cnt !== stat_exp(1)) begin errors++; $display("FAIL sim_loss_cnt got %h exp %h", loss_cnt, stat_exp(1)); end
    $display("test_simultaneous done");
  endtask

  // Runs straight after the slip issued by test_simultaneous.
  task automatic test_reset_mid_wait;
    repeat (40) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (block_lock !== 1'b0) begin errors++; $display("FAIL mw_lock got %b exp 0", block_lock); end
    checks++; if (gb_if.slip !== 1'b0) begin errors++; $display("FAIL mw_slip got %b exp 0", gb_if.slip); end
    checks++; if (slip_cnt !== 16'h0) begin errors++; $display("FAIL mw_slip_cnt got %h exp 0000", slip_cnt); end
    checks++; if (loss_cnt !== 16'h0) begin errors++; $display("FAIL mw_loss_cnt got %h exp 0000", loss_cnt); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      hdr(2'b01);
      if (i == 63) begin
        checks++; if (block_lock !== 1'b0) begin errors++; $display("FAIL mw_early got %b exp 0", block_lock); end
      end
    end
    checks++; if (block_lock !== 1'b1) begin errors++; $display("FAIL mw_relock got %b exp 1", block_lock); end
    $display("test_reset_mid_wait done");
  endtask

  task automatic test_closed_loop;
    int unsigned off, blk, pend, slips, cyc, drops, extra;
    bit prev, phase, locked;
    do_reset;
    off = 37; blk = 0; pend = 0; slips = 0; cyc = 0;
    prev = 1'b0; phase = 1'b0; locked = 1'b0;
    while (!locked && (cyc < 40000)) begin
      @(negedge clk);
      cyc++;
      if (pend > 0) begin
        pend--;
        if (pend == 0) off = (off + 1) % 66;
      end
      if ((gb_if.slip === 1'b1) && !prev) begin
        slips++;
        pend = 70;
      end
      prev = gb_if.slip;
      if (block_lock === 1'b1) locked = 1'b1;
      phase = ~phase;
      if (phase) begin
        gb_if.head = gb_head(blk, off);
        gb_if.head_valid = 1'b1;
        blk++;
      end else begin
        gb_if.head_valid = 1'b0;
      end
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL cl_lock got %b exp 1 after %0d cycles", locked, cyc); end
    checks++; if (slips !== 29) begin errors++; $display("FAIL cl_slips got %0d exp 29", slips); end
    checks++; if (off !== 0) begin errors++; $display("FAIL cl_offset got %0d exp 0", off); end
    checks++; if (slip_cnt !== stat_exp(29)) begin errors++; $display("FAIL cl_slip_cnt got %h exp %h", slip_cnt, stat_exp(29)); end
    drops = 0; extra = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if ((gb_if.slip === 1'b1) && !prev) extra++;
      prev = gb_if.slip;
      if (block_lock !== 1'b1) drops++;
      phase = ~phase;
      if (phase) begin
        gb_if.head = gb_head(blk, off);
        gb_if.head_valid = 1'b1;
        blk++;
      end else begin
        gb_if.head_valid = 1'b0;
      end
    end
    gb_if.head_valid = 1'b0;
    checks++; if (drops !== 0) begin errors++; $display("FAIL cl_stay_locked got %0d unlocked cycles exp 0", drops); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL cl_extra_slips got %0d exp 0", extra); end
    $display("test_closed_loop done");
  endtask

  initial begin
    gb_if.head = 2'b00;
    gb_if.head_valid = 1'b0;
    test_reset;
    test_acquire;
    test_slip_unlocked;
    test_error_tolerance;
    test_simultaneous;
    test_reset_mid_wait;
    test_closed_loop;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
